// File: rtl/accumulator_stream_pkg.sv
// accumulator_stream_pkg: shared FSM state type, default widths and parameter sanity check.
package accumulator_stream_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam int IN_WIDTH = 16;
  localparam int ACC_WIDTH = 32;
  localparam int OUT_WIDTH = 16;
  localparam int OUT_SCALE = 4;
  localparam int CNT_WIDTH = 8;
  function automatic bit params_ok(input int in_w, input int acc_w, input int out_w, input int scale);
    return in_w > 0 && out_w > 0 && scale >= 0 && acc_w > in_w && acc_w >= scale + out_w;
  endfunction
endpackage

// File: rtl/adder.sv
// adder: signed pairwise add, arithmetic right shift, then two's-complement wrap to out_width.
module adder #(
  parameter int a_width = 16,
  parameter int b_width = 16,
  parameter int out_width = 16,
  parameter int out_scale = 0
) (
  input  logic [a_width-1:0]   a,
  input  logic [b_width-1:0]   b,
  output logic [out_width-1:0] y
);
  localparam int sw = (a_width > b_width ? a_width : b_width) + 1;
  logic signed [sw-1:0] sum;
  assign sum = $signed(a) + $signed(b);
  assign y = out_width'(sum >>> out_scale);
endmodule

// File: rtl/accumulator_stream.sv
// accumulator_stream: sums signed operand groups and emits one rescaled word per group.
module accumulator_stream
  import accumulator_stream_pkg::*;
#(
  parameter int in_width = IN_WIDTH,
  parameter int acc_width = ACC_WIDTH,
  parameter int out_width = OUT_WIDTH,
  parameter int out_scale = OUT_SCALE,
  parameter int cnt_width = CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [in_width-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [out_width-1:0] out_data,
  output logic [cnt_width-1:0] out_count,
  output logic                 out_valid,
  input  logic                 out_ready
);
  state_t state_q, state_d;
  logic [acc_width-1:0] acc_q, acc_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [out_width-1:0] rescaled;
  logic in_hs, out_hs;
  if (!params_ok(in_width, acc_width, out_width, out_scale)) begin : g_bad_params
    $error("accumulator_stream: inconsistent width/scale parameters");
  end
  adder #(
    .a_width(acc_width),
    .b_width(1),
    .out_width(out_width),
    .out_scale(out_scale)
  ) u_rescale (
    .a(acc_q),
    .b(1'b0),
    .y(rescaled)
  );
  // Handshake flags depend on state only, so no ready->ready or valid->valid paths.
  always_comb begin
    in_ready = state_q == ACCUM;
    out_valid = state_q == HOLD;
    in_hs = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    acc_d = out_hs ? '0 : in_hs ? acc_q + {{(acc_width-in_width){in_data[in_width-1]}}, in_data} : acc_q;
    cnt_d = out_hs ? '0 : (in_hs && !(&cnt_q)) ? cnt_q + cnt_width'(1) : cnt_q;
    state_d = out_hs ? ACCUM : (in_hs && in_last) ? HOLD : state_q;
    out_data = out_valid ? rescaled : '0;
    out_count = out_valid ? cnt_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_accumulator_stream.sv
// tb_accumulator_stream: table vectors, hand-written corner sequences and a random scoreboard run.
module tb_accumulator_stream;
  logic clk = 0, rst = 1;
  logic [15:0] in_data = '0;
  logic in_valid = 0, in_last = 0, in_ready, out_valid, out_ready = 1;
  logic [15:0] out_data;
  logic [7:0] out_count;
  int n_cmp = 0, n_fail = 0;

  accumulator_stream dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int n;
    int v;
    logic [15:0] ed;
    logic [7:0] ec;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input int d, input bit last);
    int b = 0;
    in_data = 16'(d);
    in_last = last;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && b < 50) begin
      b++;
      @(negedge clk);
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic get_result(input string nm, input logic [15:0] ed, input logic [7:0] ec);
    int b = 0;
    @(negedge clk);
    while (!out_valid && b < 50) begin
      b++;
      @(negedge clk);
    end
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_data"}, {16'd0, out_data}, {16'd0, ed});
    chk({nm, "_count"}, {24'd0, out_count}, {24'd0, ec});
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q_d[$];
  logic [7:0] q_c[$];
  bit done = 0;
  int bubbles = 0;
  localparam int groups = 10000;

  initial begin
    tbl[0] = '{"seq20x3", 3, 20, 16'h0003, 8'd3};
    tbl[1] = '{"neg17", 1, -17, 16'hFFFE, 8'd1};
    tbl[2] = '{"neg1", 1, -1, 16'hFFFF, 8'd1};
    tbl[3] = '{"wrap33", 33, 32767, 16'h07FD, 8'd33};
    tbl[4] = '{"zero", 1, 0, 16'h0000, 8'd1};
    tbl[5] = '{"sat300", 300, 1, 16'h0012, 8'd255};
    tbl[6] = '{"neg1x16", 16, -1, 16'hFFFF, 8'd16};
    tbl[7] = '{"minneg", 1, -32768, 16'hF800, 8'd1};
    tbl[8] = '{"two8", 2, 8, 16'h0001, 8'd2};

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_count", {24'd0, out_count}, 32'd0);
    @(posedge clk);
    #1;

    // 10, 20, 30 back-to-back: result exactly one cycle after the last handshake, for one cycle
    in_valid = 1; in_data = 16'd10; in_last = 0;
    @(posedge clk); #1 in_data = 16'd20;
    @(posedge clk); #1 in_data = 16'd30; in_last = 1;
    @(negedge clk);
    chk("lat_pre_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1 in_valid = 0; in_last = 0;
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {16'd0, out_data}, 32'd3);
    chk("lat_count", {24'd0, out_count}, 32'd3);
    chk("lat_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("lat_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("lat_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) send(tbl[i].v, k == tbl[i].n - 1);
      get_result(tbl[i].nm, tbl[i].ed, tbl[i].ec);
    end

    // Backpressure: result must hold while a new operand waits outside
    out_ready = 0;
    send(100, 0);
    send(60, 1);
    in_valid = 1; in_data = 16'd999; in_last = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {16'd0, out_data}, 32'd10);
      chk("bp_count", {24'd0, out_count}, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 0; in_last = 0;
    @(negedge clk);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_data", {16'd0, out_data}, 32'd62);
    chk("bp_next_count", {24'd0, out_count}, 32'd1);
    @(posedge clk); #1;

    // Reset mid-group discards the partial sum
    send(100, 0);
    send(200, 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    send(48, 1);
    get_result("midrst", 16'h0003, 8'd1);

    // Reset while holding a result drops it
    out_ready = 0;
    send(5, 1);
    @(negedge clk);
    chk("holdrst_pre", {31'd0, out_valid}, 32'd1);
    rst = 1;
    @(posedge clk); #1 rst = 0; out_ready = 1;
    @(negedge clk);
    chk("holdrst_valid", {31'd0, out_valid}, 32'd0);
    chk("holdrst_data", {16'd0, out_data}, 32'd0);
    @(posedge clk); #1;

    // Random back-to-back groups against an arithmetic model
    fork
      begin
        for (int g = 0; g < groups; g++) begin
          int n;
          longint sum;
          n = $urandom_range(1, 10);
          sum = 0;
          for (int k = 0; k < n; k++) begin
            int b;
            logic [15:0] d;
            d = 16'($urandom);
            sum += longint'($signed(d));
            in_data = d;
            in_last = (k == n - 1);
            in_valid = 1;
            if (k == n - 1) begin
              q_d.push_back(16'(sum >>> 4));
              q_c.push_back(8'(n > 255 ? 255 : n));
            end
            b = 0;
            @(negedge clk);
            while (!in_ready && b < 20) begin
              b++;
              @(negedge clk);
            end
            if (!in_ready) chk("rnd_stall", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
          end
        end
        in_valid = 0;
        in_last = 0;
        repeat (4) @(posedge clk);
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (!done) begin
            if (!in_ready) bubbles++;
            if (out_valid) begin
              if (q_d.size() == 0) chk("rnd_unexpected", {31'd0, out_valid}, 32'd0);
              else begin
                logic [15:0] ed;
                logic [7:0] ec;
                ed = q_d.pop_front();
                ec = q_c.pop_front();
                chk("rnd_data", {16'd0, out_data}, {16'd0, ed});
                chk("rnd_count", {24'd0, out_count}, {24'd0, ec});
              end
            end
          end
        end
      end
    join
    chk("rnd_bubbles", bubbles, groups);
    chk("rnd_pending", q_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
